// File: rtl/bip_control.sv
// bip_control: registered multi-cycle control unit for the BIP accumulator processor.
//   Ports: i_clk/i_rst_n (async active-low reset), i_start, i_instr_valid/i_op_code/o_instr_ready
//   (opcode handshake), i_ram_ready (data RAM read valid), i_acc_zero (accumulator zero flag),
//   o_sel_A/o_sel_B/o_alu_op (datapath decode), o_r_ram/o_w_ram/o_w_acc/o_w_pc/o_pc_sel (strobes),
//   o_busy/o_halted/o_illegal (status), o_cycle_cnt/o_instr_cnt (saturating counters).
module bip_control #(
    parameter int OPBTS = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_instr_valid,
    input  logic [OPBTS-1:0] i_op_code,
    output logic             o_instr_ready,
    input  logic             i_ram_ready,
    input  logic             i_acc_zero,
    output logic [1:0]       o_sel_A,
    output logic             o_sel_B,
    output logic [2:0]       o_alu_op,
    output logic             o_r_ram,
    output logic             o_w_ram,
    output logic             o_w_acc,
    output logic             o_w_pc,
    output logic             o_pc_sel,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instr_cnt
);
    typedef enum logic [2:0] {IDLE, RUN, MEM, EXEC, HALT} state_t;

    localparam logic [OPBTS-1:0] OP_HLT = OPBTS'(0);
    localparam logic [OPBTS-1:0] OP_STO = OPBTS'(1);
    localparam logic [OPBTS-1:0] OP_LD  = OPBTS'(2);
    localparam logic [OPBTS-1:0] OP_LDI = OPBTS'(3);
    localparam logic [OPBTS-1:0] OP_ADD = OPBTS'(4);
    localparam logic [OPBTS-1:0] OP_XOR = OPBTS'(12);
    localparam logic [OPBTS-1:0] OP_SHL = OPBTS'(14);
    localparam logic [OPBTS-1:0] OP_SHR = OPBTS'(15);
    localparam logic [OPBTS-1:0] OP_BEQ = OPBTS'(16);
    localparam logic [OPBTS-1:0] OP_BNE = OPBTS'(17);
    localparam logic [OPBTS-1:0] OP_JMP = OPBTS'(18);

    state_t           state_q, state_d;
    logic [OPBTS-1:0] op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;

    // Register-operand ALU ops (ADD, SUB, AND, OR, XOR) sit on the even codes 4..12.
    function automatic logic is_mem(input logic [OPBTS-1:0] op);
        return op == OP_LD || (op >= OP_ADD && op <= OP_XOR && !op[0]);
    endfunction

    logic             busy, in_dec, exec, alu_grp;
    logic [OPBTS-1:0] alu_idx;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: state_d = i_start ? RUN : IDLE;
            RUN: if (i_instr_valid) begin
                op_d      = i_op_code;
                illegal_d = i_op_code > OP_JMP;
                state_d   = (i_op_code == OP_HLT || i_op_code > OP_JMP) ? HALT :
                            is_mem(i_op_code) ? MEM : EXEC;
            end
            MEM:  state_d = i_ram_ready ? EXEC : MEM;
            EXEC: state_d = RUN;
            default: state_d = HALT;
        endcase
        busy    = state_q == RUN || state_q == MEM || state_q == EXEC;
        exec    = state_q == EXEC;
        in_dec  = state_q == MEM || exec;
        cycle_d = (busy && cycle_q != '1) ? cycle_q + 1'b1 : cycle_q;
        instr_d = (exec && instr_q != '1) ? instr_q + 1'b1 : instr_q;
        alu_grp = op_q >= OP_ADD && op_q <= OP_SHR;
        // Each ALU function occupies a register/immediate code pair starting at ADD; SHR breaks the pairing.
        alu_idx = (op_q - OP_ADD) >> 1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_HLT;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
        end
    end

    assign o_instr_ready = state_q == RUN;
    assign o_busy        = busy;
    assign o_halted      = state_q == HALT;
    assign o_illegal     = illegal_q;
    assign o_cycle_cnt   = cycle_q;
    assign o_instr_cnt   = instr_q;
    assign o_r_ram       = state_q == MEM;
    assign o_sel_A       = !in_dec ? 2'b00 : op_q == OP_LDI ? 2'b01 : alu_grp ? 2'b10 : 2'b00;
    assign o_sel_B       = in_dec && (op_q == OP_LDI || (alu_grp && (op_q[0] || op_q == OP_SHL)));
    assign o_alu_op      = !(in_dec && alu_grp) ? 3'd0 : op_q == OP_SHR ? 3'd6 : alu_idx[2:0];
    assign o_w_acc       = exec && op_q >= OP_LD && op_q <= OP_SHR;
    assign o_w_ram       = exec && op_q == OP_STO;
    assign o_w_pc        = exec;
    // Branch resolution follows i_acc_zero live during EXEC.
    assign o_pc_sel      = exec && (op_q == OP_JMP || (op_q == OP_BEQ && i_acc_zero) ||
                                    (op_q == OP_BNE && !i_acc_zero));
endmodule
